// File: rtl/fetch_pkg.sv
// Shared definitions for the RV32I fetch stage: NOP encoding, default PC width
// and the fetch FSM state type.
package fetch_pkg;

    localparam logic [31:0] NOP_INST = 32'h0000_0013;
    localparam int          DEF_PC_W = 12;

    typedef enum logic [1:0] {
        BOOT,
        RUN,
        SQUASH
    } fetch_state_t;

endpackage

// File: rtl/instruction_fetch.sv
// Fetch stage: word-addressed PC driving a synchronous instruction memory,
// one-bubble redirect squash, and fetch/bubble performance counters.
module instruction_fetch
    import fetch_pkg::*;
#(
    parameter int              PC_W     = DEF_PC_W,
    parameter logic [PC_W-1:0] RESET_PC = '0
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            stall,
    input  logic            redirect_valid,
    input  logic [PC_W-1:0] redirect_addr,
    output logic [PC_W-1:0] imem_addr,
    output logic            imem_en,
    input  logic [31:0]     imem_rdata,
    output logic [31:0]     inst_EX,
    output logic [PC_W-1:0] prog_counter_EX,
    output logic            inst_valid_EX,
    output logic [31:0]     fetch_count,
    output logic [31:0]     bubble_count
);

    fetch_state_t    state_q, state_d;
    logic [PC_W-1:0] pc_f_q, pc_f_d;
    logic [PC_W-1:0] pc_ex_q, pc_ex_d;
    logic [31:0]     fetch_cnt_q, fetch_cnt_d;
    logic [31:0]     bubble_cnt_q, bubble_cnt_d;
    logic            redir;
    logic            advance;

    // A squashed or boot slot cannot branch, so only a RUN-state redirect counts.
    assign redir   = redirect_valid && (state_q == RUN);
    assign advance = redir || !stall;

    assign imem_addr       = pc_f_q;
    assign imem_en         = advance;
    assign inst_valid_EX   = (state_q == RUN);
    assign inst_EX         = (state_q == RUN) ? imem_rdata : NOP_INST;
    assign prog_counter_EX = pc_ex_q;
    assign fetch_count     = fetch_cnt_q;
    assign bubble_count    = bubble_cnt_q;

    always_comb begin
        state_d      = state_q;
        pc_f_d       = pc_f_q;
        pc_ex_d      = pc_ex_q;
        fetch_cnt_d  = fetch_cnt_q;
        bubble_cnt_d = bubble_cnt_q;
        if (advance) begin
            pc_ex_d = pc_f_q;
            pc_f_d  = redir ? redirect_addr : pc_f_q + 1'b1;
            if (state_q == RUN) begin
                fetch_cnt_d = fetch_cnt_q + 32'd1;
            end else begin
                bubble_cnt_d = bubble_cnt_q + 32'd1;
            end
            unique case (state_q)
                BOOT:    state_d = RUN;
                RUN:     state_d = redir ? SQUASH : RUN;
                SQUASH:  state_d = RUN;
                default: state_d = BOOT;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= BOOT;
            pc_f_q       <= RESET_PC;
            pc_ex_q      <= '0;
            fetch_cnt_q  <= '0;
            bubble_cnt_q <= '0;
        end else begin
            state_q      <= state_d;
            pc_f_q       <= pc_f_d;
            pc_ex_q      <= pc_ex_d;
            fetch_cnt_q  <= fetch_cnt_d;
            bubble_cnt_q <= bubble_cnt_d;
        end
    end

endmodule

// File: tb/tb_instruction_fetch.sv
// Randomized bench for instruction_fetch against a slot-level behavioural model
// with a synchronous ROM whose word n is 32'h00100093 + (n << 20).
module tb_instruction_fetch;

    logic        clk;
    logic        rst;
    logic        stall;
    logic        redirect_valid;
    logic [11:0] redirect_addr;
    logic [11:0] imem_addr;
    logic        imem_en;
    logic [31:0] imem_rdata;
    logic [31:0] inst_EX;
    logic [11:0] prog_counter_EX;
    logic        inst_valid_EX;
    logic [31:0] fetch_count;
    logic [31:0] bubble_count;

    int n_vec;
    int n_err;

    // Behavioural model: only whether EX holds a real instruction matters.
    logic        m_valid;
    logic [11:0] m_pcf;
    logic [11:0] m_pcex;
    logic [31:0] m_fc;
    logic [31:0] m_bc;

    instruction_fetch #(
        .PC_W    (12),
        .RESET_PC(12'h000)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .stall          (stall),
        .redirect_valid (redirect_valid),
        .redirect_addr  (redirect_addr),
        .imem_addr      (imem_addr),
        .imem_en        (imem_en),
        .imem_rdata     (imem_rdata),
        .inst_EX        (inst_EX),
        .prog_counter_EX(prog_counter_EX),
        .inst_valid_EX  (inst_valid_EX),
        .fetch_count    (fetch_count),
        .bubble_count   (bubble_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] rom_word(input logic [11:0] a);
        return 32'h0010_0093 + ({20'h0, a} << 20);
    endfunction

    always @(posedge clk) begin
        if (imem_en) imem_rdata <= rom_word(imem_addr);
    end

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_valid = 1'b0;
        m_pcf   = 12'h000;
        m_pcex  = 12'h000;
        m_fc    = 32'd0;
        m_bc    = 32'd0;
    endtask

    // Called just after a rising edge: drive, check, clock, update the model.
    task automatic cycle(input logic r, input logic s, input logic rv, input logic [11:0] ra);
        logic taken;
        rst            = r;
        stall          = s;
        redirect_valid = rv;
        redirect_addr  = ra;
        #1;
        taken = rv && m_valid;
        check_val("imem_addr", {20'h0, imem_addr}, {20'h0, m_pcf});
        check_val("imem_en", {31'h0, imem_en}, {31'h0, (!s || taken)});
        check_val("inst_valid_EX", {31'h0, inst_valid_EX}, {31'h0, m_valid});
        check_val("inst_EX", inst_EX, m_valid ? rom_word(m_pcex) : 32'h0000_0013);
        check_val("prog_counter_EX", {20'h0, prog_counter_EX}, {20'h0, m_pcex});
        check_val("fetch_count", fetch_count, m_fc);
        check_val("bubble_count", bubble_count, m_bc);
        @(posedge clk);
        if (r) begin
            model_reset();
        end else if (taken || !s) begin
            if (m_valid) m_fc = m_fc + 32'd1;
            else         m_bc = m_bc + 32'd1;
            m_pcex  = m_pcf;
            m_pcf   = taken ? ra : m_pcf + 12'd1;
            m_valid = !taken;
        end
        #1;
    endtask

    initial begin
        int guard;
        n_vec = 0;
        n_err = 0;
        rst = 1'b1;
        stall = 1'b0;
        redirect_valid = 1'b0;
        redirect_addr = 12'h000;
        model_reset();
        @(posedge clk);
        @(posedge clk);
        #1;
        cycle(1'b1, 1'b0, 1'b0, 12'h000);

        // Boot bubble followed by sequential fetch from the reset PC.
        for (int i = 0; i < 6; i++) cycle(1'b0, 1'b0, 1'b0, 12'h000);

        // Redirect while EX holds PC 5.
        guard = 0;
        while (!(m_valid && m_pcex == 12'd5) && guard < 20) begin
            cycle(1'b0, 1'b0, 1'b0, 12'h000);
            guard++;
        end
        check_val("reach_pc5", {31'h0, (guard < 20)}, 32'd1);
        cycle(1'b0, 1'b0, 1'b1, 12'h020);
        cycle(1'b0, 1'b0, 1'b0, 12'h000);
        cycle(1'b0, 1'b0, 1'b1, 12'h007);
        cycle(1'b0, 1'b0, 1'b0, 12'h000);

        // Three stalled cycles at PC 7, then resume.
        for (int i = 0; i < 3; i++) cycle(1'b0, 1'b1, 1'b0, 12'h000);
        cycle(1'b0, 1'b0, 1'b0, 12'h000);
        cycle(1'b0, 1'b0, 1'b0, 12'h000);

        // Stall and redirect together: the redirect wins.
        cycle(1'b0, 1'b1, 1'b1, 12'h100);
        cycle(1'b0, 1'b0, 1'b0, 12'h000);
        cycle(1'b0, 1'b0, 1'b0, 12'h000);

        // PC wrap from FFE through 000.
        cycle(1'b0, 1'b0, 1'b1, 12'hFFE);
        for (int i = 0; i < 4; i++) cycle(1'b0, 1'b0, 1'b0, 12'h000);

        // Redirect attempted from a squashed slot is ignored, even with stall.
        cycle(1'b0, 1'b0, 1'b1, 12'h040);
        cycle(1'b0, 1'b1, 1'b1, 12'h300);
        cycle(1'b0, 1'b0, 1'b1, 12'h300);
        cycle(1'b0, 1'b0, 1'b0, 12'h000);

        // Reset during SQUASH.
        cycle(1'b0, 1'b0, 1'b1, 12'h050);
        cycle(1'b1, 1'b0, 1'b0, 12'h000);
        cycle(1'b0, 1'b0, 1'b0, 12'h000);
        cycle(1'b0, 1'b0, 1'b0, 12'h000);

        // Randomized traffic, including reset during stall.
        for (int i = 0; i < 3000; i++) begin
            logic       r;
            logic       s;
            logic       rv;
            logic [11:0] ra;
            r  = ($urandom_range(0, 99) < 2);
            s  = ($urandom_range(0, 99) < 25);
            rv = ($urandom_range(0, 99) < 20);
            ra = ($urandom_range(0, 3) == 0) ? 12'hFFC + 12'($urandom_range(0, 3))
                                             : 12'($urandom);
            cycle(r, s, rv, ra);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
